mips_multicycle_controller: RTL
===============================

// Module: mips_multicycle_controller
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath: drives every control input of MIPSDatapath
//  from IR contents (Instruction) and ZeroFlag. One instruction at a time:
//  FETCH -> DECODE -> class-specific states -> FETCH.
//  Supports R-type add/sub/and/or/slt/jr, lw, sw, beq, addi, slti, j, jal.
// PARAMETERS
//  ILLEGAL_TRAP  0  1: an unknown opcode/funct parks the FSM in HALT until rst; 0: it returns to FETCH.
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   reset; synchronous, active-high
//  Instruction   in   32  IR output; op=[31:26], funct=[5:0]
//  ZeroFlag      in   1   ALU zero; consumed only by PCWriteCond in the datapath
//  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite   out 1 each
//  RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA   out 1 each
//  ALUSrcB       out  2   00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  PCSrc         out  2   00 ALU result, 01 jump addr, 10 ALUout reg, 11 A reg
//  ALUoperation  out  3   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  InstrDone     out  1   1-cycle pulse in the last state of each instruction
//  IllegalOp     out  1   1-cycle pulse in DECODE when op/funct is unsupported
// BEHAVIOUR
//  - Reset: when rst is sampled high at a posedge, state <= FETCH. While rst=1, all outputs are forced to 0.
//    Reset mid-instruction abandons the instruction; no write is issued after rst rises.
//  - Moore outputs, decoded from state only. Every output not listed for a state is 0.
//  - FETCH: MemRead, IRWrite, ALUSrcB=01, ADD, PCWrite, PCSrc=00 (PC<=PC+4, IR<=Mem[PC]) -> DECODE.
//  - DECODE: ALUSrcB=11, ADD (ALUout<=branch target).
//    Next state: op 000000 funct jr -> JR, other valid funct -> REXEC; 100011/101011 -> MEMADR;
//    000100 -> BEQ; 001000/001010 -> IEXEC; 000010 -> JUMP; 000011 -> JAL;
//    otherwise IllegalOp=1 and go to HALT (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: IorD, MemRead -> MEMWB.
//  - MEMWB: MemtoReg, RegWrite (RegDst=0), InstrDone -> FETCH.
//  - MEMWR: IorD, MemWrite, InstrDone -> FETCH.
//  - REXEC: ALUSrcA=1, ALUSrcB=00, ALUoperation from funct
//    (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT) -> RWB.
//  - RWB: RegDst, RegWrite, InstrDone -> FETCH.
//  - IEXEC: ALUSrcA=1, ALUSrcB=10, ADD (addi) or SLT (slti) -> IWB.
//  - IWB: RegWrite (RegDst=0, MemtoReg=0), InstrDone -> FETCH.
//  - BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSrc=10, InstrDone -> FETCH.
//  - JUMP: PCWrite, PCSrc=01, InstrDone -> FETCH.
//  - JAL: PCWrite, PCSrc=01, WriteRegSel, WriteDataSel, RegWrite, InstrDone -> FETCH.
//    $31 receives the current PC (already PC+4).
//  - JR: PCWrite, PCSrc=11, InstrDone -> FETCH.
//  - HALT: all outputs 0. Stays in HALT until rst.
//  - Latency in cycles, FETCH inclusive: lw 5; R/sw/addi/slti 4; beq/j/jal/jr 3. No overlap between instructions.
//  - MemRead and MemWrite are never asserted together. RegWrite is never asserted together with PCWriteCond.
//  - Unreachable state encodings go to FETCH with all outputs 0.
// STRUCTURE
//  - mips_ctrl_pkg holds: state_t enum; OP_* and FUNCT_* opcode constants; ALU_AND/OR/ADD/SUB/SLT
//    constants; PCSRC_* and SRCB_* select constants.
//  - Sub-module mips_alu_decoder (combinational): inputs funct and 2-bit aluop class
//    (add/sub/funct/slt); outputs ALUoperation and funct_valid.
//  - Controller: state register + next-state logic + output decode.
// TESTING
//  - rst=1 for 2 cycles then released -> all outputs 0 during rst; cycle 1 after release is FETCH
//    (MemRead=IRWrite=PCWrite=1, ALUSrcB=01, ALUoperation=010).
//  - Instruction=0x00221820 (add $3,$1,$2) -> FETCH, DECODE, REXEC (ALUop 010, SrcA=1, SrcB=00),
//    RWB (RegDst=RegWrite=1); InstrDone on cycle 4.
//  - Instruction=0x8C220008 (lw) -> 5 states; MEMRD has IorD=MemRead=1;
//    MEMWB has MemtoReg=RegWrite=1, RegDst=0.
//  - Instruction=0x10220003 (beq) with ZeroFlag=0 and with ZeroFlag=1 -> BEQ has PCWriteCond=1,
//    PCSrc=10, ALUop 110; PCWrite=0 in both runs; 3 cycles.
//  - Instruction=0x0C000010 (jal), then 0x03E00008 (jr $31) -> JAL: WriteRegSel=WriteDataSel=RegWrite=PCWrite=1,
//    PCSrc=01; JR: PCWrite=1, PCSrc=11.
//  - Instruction=0xFC000000 -> IllegalOp pulse in DECODE.
//    ILLEGAL_TRAP=0: next state FETCH. ILLEGAL_TRAP=1: outputs stay 0 until rst.
//    Also assert rst during MEMWR -> no MemWrite after rst rises.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state type, opcode and funct
// encodings, ALU operation codes, ALU-class selects and datapath mux select constants.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StIExec  = 4'd8,
    StIWb    = 4'd9,
    StBeq    = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StJr     = 4'd13,
    StHalt   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder.
//   i_funct           : instruction funct field [5:0]
//   i_aluop           : ALU class (add / sub / from funct / slt)
//   o_alu_operation   : 3-bit ALU operation code
//   o_funct_valid     : funct is one of the supported arithmetic/logic R-type functions
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic [1:0] i_aluop,
  output logic [2:0] o_alu_operation,
  output logic       o_funct_valid
);

  logic [2:0] w_funct_op;

  always_comb begin
    w_funct_op    = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      FUNCT_ADD: w_funct_op = ALU_ADD;
      FUNCT_SUB: w_funct_op = ALU_SUB;
      FUNCT_AND: w_funct_op = ALU_AND;
      FUNCT_OR:  w_funct_op = ALU_OR;
      FUNCT_SLT: w_funct_op = ALU_SLT;
      default:   o_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    o_alu_operation = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD:   o_alu_operation = ALU_ADD;
      ALUOP_SUB:   o_alu_operation = ALU_SUB;
      ALUOP_FUNCT: o_alu_operation = w_funct_op;
      ALUOP_SLT:   o_alu_operation = ALU_SLT;
      default:     o_alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM controlling the multicycle MIPS datapath.
//   clk, rst        : clock, synchronous active-high reset (outputs forced low while rst=1)
//   Instruction     : IR contents; op=[31:26], funct=[5:0]
//   ZeroFlag        : ALU zero (used by the datapath via PCWriteCond, not by this FSM)
//   PCWrite..ALUSrcA: single-bit datapath controls
//   ALUSrcB, PCSrc  : mux selects; ALUoperation : ALU op code
//   InstrDone       : pulse in the last state of each instruction
//   IllegalOp       : pulse in DECODE for an unsupported op/funct
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        ZeroFlag,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        WriteRegSel,
  output logic        MemtoReg,
  output logic        WriteDataSel,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUoperation,
  output logic        InstrDone,
  output logic        IllegalOp
);

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [1:0] w_aluop;
  logic [2:0] w_alu_operation;
  logic       w_funct_valid;
  logic       w_illegal;
  logic       w_unused;

  assign w_op     = Instruction[31:26];
  assign w_funct  = Instruction[5:0];
  assign w_unused = ^{Instruction[25:6], ZeroFlag};

  // Only REXEC, IEXEC and BEQ need anything other than ADD
  always_comb begin
    w_aluop = ALUOP_ADD;
    case (r_state)
      StRExec: w_aluop = ALUOP_FUNCT;
      StIExec: w_aluop = (w_op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      StBeq:   w_aluop = ALUOP_SUB;
      default: w_aluop = ALUOP_ADD;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .i_funct         (w_funct),
    .i_aluop         (w_aluop),
    .o_alu_operation (w_alu_operation),
    .o_funct_valid   (w_funct_valid)
  );

  always_comb begin
    case (w_op)
      OP_RTYPE: w_illegal = !(w_funct_valid || (w_funct == FUNCT_JR));
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL: w_illegal = 1'b0;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StFetch;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch: w_state_next = StDecode;
      StDecode: begin
        if (w_illegal) begin
          w_state_next = ILLEGAL_TRAP ? StHalt : StFetch;
        end else begin
          case (w_op)
            OP_RTYPE:        w_state_next = (w_funct == FUNCT_JR) ? StJr : StRExec;
            OP_LW, OP_SW:    w_state_next = StMemAdr;
            OP_BEQ:          w_state_next = StBeq;
            OP_ADDI, OP_SLTI: w_state_next = StIExec;
            OP_J:            w_state_next = StJump;
            OP_JAL:          w_state_next = StJal;
            default:         w_state_next = StFetch;
          endcase
        end
      end
      StMemAdr: begin
        if (w_op == OP_LW)      w_state_next = StMemRd;
        else if (w_op == OP_SW) w_state_next = StMemWr;
        else                    w_state_next = StFetch;
      end
      StMemRd: w_state_next = StMemWb;
      StRExec: w_state_next = StRWb;
      StIExec: w_state_next = StIWb;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;  // last states of each class and unused encodings
    endcase
  end

  // Moore output decode; everything held low during reset so no write leaks out
  always_comb begin
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    WriteRegSel  = 1'b0;
    MemtoReg     = 1'b0;
    WriteDataSel = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    PCSrc        = PCSRC_ALU;
    ALUoperation = 3'b000;
    InstrDone    = 1'b0;
    IllegalOp    = 1'b0;
    if (!rst) begin
      case (r_state)
        StFetch: begin
          MemRead      = 1'b1;
          IRWrite      = 1'b1;
          ALUSrcB      = SRCB_FOUR;
          ALUoperation = w_alu_operation;
          PCWrite      = 1'b1;
          PCSrc        = PCSRC_ALU;
        end
        StDecode: begin
          ALUSrcB      = SRCB_IMM_SH;
          ALUoperation = w_alu_operation;
          IllegalOp    = w_illegal;
        end
        StMemAdr, StIExec: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_IMM;
          ALUoperation = w_alu_operation;
        end
        StMemRd: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        StMemWb: begin
          MemtoReg  = 1'b1;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StMemWr: begin
          IorD      = 1'b1;
          MemWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StRExec: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_B;
          ALUoperation = w_alu_operation;
        end
        StRWb: begin
          RegDst    = 1'b1;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StIWb: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StBeq: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_B;
          ALUoperation = w_alu_operation;
          PCWriteCond  = 1'b1;
          PCSrc        = PCSRC_ALUOUT;
          InstrDone    = 1'b1;
        end
        StJump: begin
          PCWrite   = 1'b1;
          PCSrc     = PCSRC_JUMP;
          InstrDone = 1'b1;
        end
        StJal: begin
          PCWrite      = 1'b1;
          PCSrc        = PCSRC_JUMP;
          WriteRegSel  = 1'b1;
          WriteDataSel = 1'b1;
          RegWrite     = 1'b1;
          InstrDone    = 1'b1;
        end
        StJr: begin
          PCWrite   = 1'b1;
          PCSrc     = PCSRC_REG_A;
          InstrDone = 1'b1;
        end
        default: ;  // HALT and unused encodings drive nothing
      endcase
    end
  end

endmodule
